// File: rtl/scr_trigger_gen_pkg.sv
// Shared timing constants and FSM state encoding for the SCR trigger generator
// and the breakdown detector that consumes its pulses.
package scr_trigger_gen_pkg;

  localparam int DEF_PULSE_WIDTH = 500;
  localparam int DEF_HALF_PERIOD = 500000;
  localparam int DEF_GUARD_TIME  = 1000;
  localparam int TIMER_W         = 20;
  localparam int CNT_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    FWD_PULSE,
    FWD_GAP,
    NEG_PULSE,
    NEG_GAP
  } trig_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/scr_trigger_gen.sv
// Alternating forward/negative SCR trigger pulse generator with forbid gate.
// One run = guard interval followed by N complete forward/negative pairs.
module scr_trigger_gen
  import scr_trigger_gen_pkg::*;
#(
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int GUARD_TIME  = DEF_GUARD_TIME
) (
  input  logic             i_clk_50m,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_cycles,
  output logic             o_signal_forward,
  output logic             o_signal_negative,
  output logic             o_signal_forbid,
  output logic             o_busy,
  output logic             o_cycle_done,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  // Timer reload values: the timer counts down to zero, so each state lasts load+1 clocks.
  localparam logic [TIMER_W-1:0] PW_LOAD    = TIMER_W'(PULSE_WIDTH - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(HALF_PERIOD - PULSE_WIDTH - 1);
  localparam logic [TIMER_W-1:0] GUARD_LOAD = TIMER_W'(GUARD_TIME - 1);

  trig_state_t        state;
  logic [TIMER_W-1:0] timer;
  logic               run_q;
  logic [CNT_W-1:0]   cycles_lat;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   next_cnt;
  logic               timer_zero;

  assign next_cnt    = sat_inc(cycle_cnt);
  assign timer_zero  = (timer == '0);
  assign o_cycle_cnt = cycle_cnt;

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state             <= IDLE;
      timer             <= '0;
      run_q             <= 1'b0;
      cycles_lat        <= '0;
      cycle_cnt         <= '0;
      o_signal_forward  <= 1'b0;
      o_signal_negative <= 1'b0;
      o_signal_forbid   <= 1'b1;
      o_busy            <= 1'b0;
      o_cycle_done      <= 1'b0;
    end else begin
      run_q        <= i_run;
      o_cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          // Only a fresh rising edge starts a run; a level held across a run end does not.
          if (i_run && !run_q) begin
            cycles_lat      <= i_cycles;
            cycle_cnt       <= '0;
            timer           <= GUARD_LOAD;
            state           <= GUARD;
            o_signal_forbid <= 1'b0;
            o_busy          <= 1'b1;
          end
        end
        GUARD: begin
          if (timer_zero) begin
            timer            <= PW_LOAD;
            state            <= FWD_PULSE;
            o_signal_forward <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        FWD_PULSE: begin
          if (timer_zero) begin
            timer            <= GAP_LOAD;
            state            <= FWD_GAP;
            o_signal_forward <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        FWD_GAP: begin
          if (timer_zero) begin
            timer             <= PW_LOAD;
            state             <= NEG_PULSE;
            o_signal_negative <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        NEG_PULSE: begin
          if (timer_zero) begin
            timer             <= GAP_LOAD;
            state             <= NEG_GAP;
            o_signal_negative <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        NEG_GAP: begin
          // The strobe is raised one clock early so it sits on the gap's final clock.
          if (timer == TIMER_W'(1)) begin
            o_cycle_done <= 1'b1;
          end
          if (timer_zero) begin
            cycle_cnt <= next_cnt;
            if (!i_run || (cycles_lat != '0 && cycles_lat == next_cnt)) begin
              state           <= IDLE;
              o_signal_forbid <= 1'b1;
              o_busy          <= 1'b0;
            end else begin
              timer            <= PW_LOAD;
              state            <= FWD_PULSE;
              o_signal_forward <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state             <= IDLE;
          o_signal_forward  <= 1'b0;
          o_signal_negative <= 1'b0;
          o_signal_forbid   <= 1'b1;
          o_busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule
